// File: rtl/serial_bit_tx_pkg.sv
// Purpose  : shared FSM state encoding for the serial bit transmitter.
// Latency  : n/a (types and constants only).
// Backpressure: n/a.
package serial_bit_tx_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/serial_bit_cnt.sv
// Purpose  : bit-position counter for one serial word, flags the final bit.
// Latency  : count updates on the clock edge after clr/inc; last is combinational from the count.
// Backpressure: none; the owner stops incrementing at the last bit so the count never wraps.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count at zero (wins over inc)
//   inc      : advance the count by one
//   last     : count == WIDTH-1
module serial_bit_cnt
    import serial_bit_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_bit_tx.sv
// Purpose  : parallel-to-serial transmitter, WIDTH-bit word shifted out LSB first on d/d_en.
// Latency  : bit 0 appears on d one cycle after the load handshake; done pulses one cycle after the final bit.
// Backpressure: load_ready is low for the whole word; load_valid/load_data are ignored while busy.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_valid : word offered on load_data
//   load_data  : word to send, captured on the handshake
//   load_ready : ready for a new word (IDLE only)
//   d, d_en    : serial bit and its qualifier, both registered
//   busy       : word in flight
//   done       : one-cycle pulse in the first IDLE cycle after the final bit
//
// Build option: define SERIAL_BIT_TX_PARITY_EN to append an even-parity bit after each word.
module serial_bit_tx
    import serial_bit_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             d,
    output logic             d_en,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;

    logic load_ready_nxt;
    logic d_nxt;
    logic d_en_nxt;
    logic busy_nxt;
    logic done_nxt;

    logic cnt_clr;
    logic cnt_inc;
    logic cnt_last;

`ifdef SERIAL_BIT_TX_PARITY_EN
    // Parity is taken from the word at load time because the shift
    // register has been emptied by the time the parity bit goes out.
    logic par_q;
    logic par_nxt;
`endif

    serial_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    // Output values are computed for the *next* cycle so that every
    // output comes straight from a flop.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        d_nxt     = 1'b0;
        d_en_nxt  = 1'b0;
        done_nxt  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nxt = SHIFT;
                    shreg_nxt = load_data;
                    cnt_clr   = 1'b1;
                    d_nxt     = load_data[0];
                    d_en_nxt  = 1'b1;
`ifdef SERIAL_BIT_TX_PARITY_EN
                    par_nxt   = ^load_data;
`endif
                end
            end
            SHIFT: begin
                // shreg[0] is the bit on d this cycle; the next bit is
                // bit 0 of the shifted value.
                shreg_nxt = shreg >> 1;
                if (cnt_last) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
                    state_nxt = PARITY;
                    d_nxt     = par_q;
                    d_en_nxt  = 1'b1;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end else begin
                    cnt_inc  = 1'b1;
                    d_nxt    = shreg_nxt[0];
                    d_en_nxt = 1'b1;
                end
            end
`ifdef SERIAL_BIT_TX_PARITY_EN
            PARITY: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase

        load_ready_nxt = (state_nxt == IDLE);
        busy_nxt       = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            load_ready <= 1'b1;
            d          <= 1'b0;
            d_en       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            load_ready <= load_ready_nxt;
            d          <= d_nxt;
            d_en       <= d_en_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
`ifdef SERIAL_BIT_TX_PARITY_EN
            par_q      <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Purpose  : self-checking bench for serial_bit_tx (scoreboard of expected serial bits).
// Latency  : expects bit 0 one cycle after the handshake and done one cycle after the final bit.
// Backpressure: drives load_valid only when load_ready is seen high, except the deliberate busy-load case.
module tb_serial_bit_tx;

    localparam int W = 8;
`ifdef SERIAL_BIT_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         d;
    logic         d_en;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    serial_bit_tx #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .d          (d),
        .d_en       (d_en),
        .busy       (busy),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic b;
        logic last;
    } exp_bit_t;

    // seq is written in transmission order: seq[W-1] goes out first.
    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] seq;
        logic         par;
    } vec_t;

    exp_bit_t sb[$];
    logic     done_pend = 1'b0;
    int       bits_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every valid bit is popped from the scoreboard, and
    // done must be high exactly in the cycle after a word's final bit.
    always @(negedge clk) begin : mon
        exp_bit_t e;
        if (rst) begin
            done_pend = 1'b0;
        end else begin
            chk("done", {31'd0, done}, {31'd0, done_pend});
            if (done_pend) chk("gap_d_en", {31'd0, d_en}, 32'd0);
            done_pend = 1'b0;
            if (d_en) begin
                bits_seen++;
                chk("ready_low_while_busy", {31'd0, load_ready}, 32'd0);
                chk("busy_high", {31'd0, busy}, 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: d_en=1 d=%0b with no bit expected at %0t", d, $time);
                end else begin
                    e = sb.pop_front();
                    chk("d", {31'd0, d}, {31'd0, e.b});
                    done_pend = e.last;
                end
            end
        end
    end

    // Receiver: a plain DFF on d/d_en, reassembling the first W bits of each burst.
    logic         rx_q;
    logic         rx_en_q;
    logic [W-1:0] rx_word = '0;
    logic [W-1:0] rx_last = '0;
    int           rx_cnt  = 0;

    always @(posedge clk) begin
        rx_q    <= d;
        rx_en_q <= d_en;
    end

    always @(negedge clk) begin
        if (rx_en_q) begin
            if (rx_cnt < W) begin
                rx_word = {rx_q, rx_word[W-1:1]};
                rx_cnt++;
                if (rx_cnt == W) rx_last = rx_word;
            end
        end else begin
            rx_cnt = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input vec_t v);
        exp_bit_t e;
        for (int i = 0; i < W; i++) begin
            e.b    = v.seq[W-1-i];
            e.last = (i == W - 1) && (PAR == 0);
            sb.push_back(e);
        end
        if (PAR != 0) begin
            e.b    = v.par;
            e.last = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (load_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: load_ready stuck at %0b, required 1", load_ready);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || load_ready !== 1'b1 || done_pend) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: %0d bits outstanding, load_ready=%0b, required idle", sb.size(), load_ready);
        end
    endtask

    task automatic wait_bits(input int target);
        int n = 0;
        while (bits_seen < target && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_bits: saw %0d bits, required %0d", bits_seen, target);
        end
    endtask

    task automatic send(input vec_t v);
        wait_ready();
        load_valid = 1'b1;
        load_data  = v.data;
        push_word(v);
        step();
        load_valid = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t v_ff, v_00, v_81, v_3c, v_f0, v_01;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        vecs[0] = '{data: 8'hA5, seq: 8'b10100101, par: 1'b0};
        vecs[1] = '{data: 8'hC3, seq: 8'b11000011, par: 1'b0};
        vecs[2] = '{data: 8'h17, seq: 8'b11101000, par: 1'b0};
        vecs[3] = '{data: 8'h07, seq: 8'b11100000, par: 1'b1};
        vecs[4] = '{data: 8'h5A, seq: 8'b01011010, par: 1'b0};
        vecs[5] = '{data: 8'h80, seq: 8'b00000001, par: 1'b1};
        v_ff    = '{data: 8'hFF, seq: 8'b11111111, par: 1'b0};
        v_00    = '{data: 8'h00, seq: 8'b00000000, par: 1'b0};
        v_81    = '{data: 8'h81, seq: 8'b10000001, par: 1'b0};
        v_3c    = '{data: 8'h3C, seq: 8'b00111100, par: 1'b0};
        v_f0    = '{data: 8'hF0, seq: 8'b00001111, par: 1'b0};
        v_01    = '{data: 8'h01, seq: 8'b10000000, par: 1'b1};

        // Reset
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (3) step();
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_d",          {31'd0, d},          32'd0);
        chk("rst_d_en",       {31'd0, d_en},       32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, load_ready}, 32'd1);

        // Table of single words
        for (int i = 0; i < 6; i++) begin
            base = bits_seen;
            send(vecs[i]);
            chk("first_bit_latency", bits_seen - base, 32'd1);
            wait_idle();
            chk("bits_per_word", bits_seen - base, W + PAR);
            if (vecs[i].data == 8'h5A) begin
                step();
                chk("loopback_word", {24'd0, rx_last}, 32'h5A);
            end
        end

        // Back-to-back FF then 00 with load_valid held high
        wait_ready();
        load_valid = 1'b1;
        load_data  = v_ff.data;
        push_word(v_ff);
        step();
        load_data = v_00.data;
        push_word(v_00);
        for (int k = 0; k < 2 * (W + PAR) + 1; k++) begin
            chk("b2b_d_en_pattern", {31'd0, d_en}, (k == W + PAR) ? 32'd0 : 32'd1);
            if (k == W + PAR) chk("b2b_gap_done", {31'd0, done}, 32'd1);
            if (k == W + PAR + 1) load_valid = 1'b0;
            step();
        end
        load_valid = 1'b0;
        wait_idle();

        // Load attempt while busy: 3C offered during bit 3 of 81
        base = bits_seen;
        send(v_81);
        wait_bits(base + 4);
        chk("busy_ready_low", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b1;
        load_data  = v_3c.data;
        step();
        load_valid = 1'b0;
        wait_idle();
        repeat (W + 3) step();
        chk("busy_load_ignored", bits_seen - base, W + PAR);

        // Reset in the middle of F0, during bit 4
        base = bits_seen;
        send(v_f0);
        wait_bits(base + 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_d_en", {31'd0, d_en},       32'd0);
        chk("mid_rst_d",    {31'd0, d},          32'd0);
        chk("mid_rst_busy", {31'd0, busy},       32'd0);
        chk("mid_rst_ready",{31'd0, load_ready}, 32'd1);
        sb.delete();
        repeat (2) step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("after_rst_no_done", {31'd0, done}, 32'd0);
            chk("after_rst_idle",    {31'd0, load_ready}, 32'd1);
        end

        // Fresh word after the abandoned one
        base = bits_seen;
        send(v_01);
        wait_idle();
        chk("post_rst_word_bits", bits_seen - base, W + PAR);
        step();
        chk("post_rst_loopback", {24'd0, rx_last}, 32'h01);

        repeat (5) step();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
